// File: rtl/match_move_driver.sv
// match_move_driver: replays a FIFO of signed moves into the candle game as timed SW/BTNC presses,
// stopping and flushing when the candle goes out or on abort.
module match_move_driver #(
    parameter int DEPTH          = 16,
    parameter int SETUP_CYCLES   = 4,
    parameter int PRESS_CYCLES   = 100,
    parameter int RELEASE_CYCLES = 100,
    parameter int SETTLE_CYCLES  = 10
) (
    input  logic                     CLK100MHZ,
    input  logic                     BTNR_N,
    input  logic                     load_valid,
    input  logic [3:0]               load_move,
    output logic                     load_ready,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               LED,
    input  logic                     extinguish,
    output logic [3:0]               SW,
    output logic                     BTNC,
    output logic                     busy,
    output logic                     done,
    output logic                     extinguished,
    output logic [7:0]               moves_issued,
    output logic [7:0]               last_led,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int M1 = SETUP_CYCLES > PRESS_CYCLES ? SETUP_CYCLES : PRESS_CYCLES;
    localparam int M2 = RELEASE_CYCLES > SETTLE_CYCLES ? RELEASE_CYCLES : SETTLE_CYCLES;
    localparam int MAXC = M1 > M2 ? M1 : M2;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] L_PRESS = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] L_REL = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] L_SET = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, POP, SETUP, PRESS, RELEASE, SETTLE} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic push, pop, flush, fin, go, enter_press, latch, pend, pend_set, last, stop, has_data;

    assign load_ready = fifo_count != FULL;
    assign push = load_valid && load_ready;
    assign has_data = fifo_count != '0;
    assign stop = abort || extinguish;
    assign BTNC = state == PRESS;
    assign busy = state != IDLE;
    assign last = state == SETUP ? cnt == L_SETUP :
                  state == PRESS ? cnt == L_PRESS :
                  state == RELEASE ? cnt == L_REL : cnt == L_SET;

    always_comb begin
        state_n = state;
        pop = 1'b0;
        flush = 1'b0;
        fin = 1'b0;
        go = 1'b0;
        enter_press = 1'b0;
        latch = 1'b0;
        pend_set = 1'b0;
        case (state)
            IDLE: begin
                flush = abort;
                go = start && !abort && has_data;
                fin = start && !abort && !has_data;
                state_n = go ? POP : IDLE;
            end
            POP: begin
                flush = stop;
                fin = stop;
                pop = !stop;
                state_n = stop ? IDLE : SETUP;
            end
            SETUP: begin
                flush = stop;
                fin = stop;
                enter_press = !stop && last;
                state_n = stop ? IDLE : last ? PRESS : SETUP;
            end
            PRESS: begin
                // a stop request during a press lets the press and its release finish
                pend_set = stop;
                state_n = last ? RELEASE : PRESS;
            end
            RELEASE: begin
                flush = (stop && !pend) || (last && pend);
                fin = flush;
                state_n = flush ? IDLE : last ? SETTLE : RELEASE;
            end
            SETTLE: begin
                flush = stop;
                latch = !stop && last;
                fin = stop || (last && !has_data);
                state_n = fin ? IDLE : last ? POP : SETTLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!BTNR_N) begin
            state <= IDLE;
            cnt <= '0;
            pend <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_count <= '0;
            SW <= 4'd0;
            done <= 1'b0;
            extinguished <= 1'b0;
            moves_issued <= 8'd0;
            last_led <= 8'd0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
            pend <= state_n == IDLE ? 1'b0 : pend | pend_set;
            done <= fin;
            extinguished <= go ? 1'b0 : extinguished | (busy & extinguish);
            moves_issued <= go ? 8'd0 : (enter_press && moves_issued != 8'hFF) ? moves_issued + 8'd1 : moves_issued;
            last_led <= latch ? LED : last_led;
            SW <= pop ? mem[rd_ptr] : state_n == IDLE ? 4'd0 : SW;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                fifo_count <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
                fifo_count <= fifo_count + FW'(push) - FW'(pop);
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push && !flush) mem[wr_ptr] <= load_move;
    end
endmodule
